xc_aessub_unit: RTL and testbench
=================================

XC_AESSUB_UNIT -- requirements
Module: xc_aessub_unit

Interface
REQ-001 The block SHALL have no parameters; the only build option is the macro in Configuration.
REQ-002 clock  in  1  single clock; all state SHALL update on its rising edge only.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 valid  in  1  operation request; held high by the pipeline until ready is seen.
REQ-005 rs1  in  32  source register 1.
REQ-006 rs2  in  32  source register 2.
REQ-007 enc  in  1  1 = forward AES S-box; 0 = inverse S-box.
REQ-008 rot  in  1  1 = rotate the packed result left by 8 bits.
REQ-009 ready  out  1  one-cycle pulse marking result valid.
REQ-010 result  out  32  packed substituted word; valid only while ready=1.

Function
REQ-011 Byte i of the result SHALL be sbox(rs1 byte i) for i = 0, 2 and sbox(rs2 byte i) for i = 1, 3. sbox is forward when enc=1 and inverse when enc=0.
REQ-012 When rot=1, result SHALL be the REQ-011 word rotated left by 8 bits: {b2, b1, b0, b3}.
REQ-013 The FSM SHALL have states IDLE, BUSY and DONE; reset SHALL force IDLE.
REQ-014 IDLE with valid=1: substitute byte 0 from the live inputs, latch rs1, rs2, enc and rot into operand registers, set the byte counter to 1, and go to BUSY.
REQ-015 BUSY: each cycle, substitute the byte selected by the counter from the latched operands and write it to the result register; counter 3 -> DONE, otherwise increment.
REQ-016 DONE: assert ready for exactly that cycle, present result with rot applied, and return to IDLE.
REQ-017 Latency SHALL be 4 cycles: valid first sampled high at edge N gives ready=1 in the cycle after edge N+3.
REQ-018 If valid=1 in the cycle after DONE, a new operation SHALL start from IDLE; back-to-back throughput is one result per 5 cycles.
REQ-019 Operands SHALL be taken from the latched copies after the first cycle; input changes while BUSY SHALL NOT affect the result.
REQ-020 valid=0 while BUSY SHALL abort: the FSM returns to IDLE next cycle and ready is not asserted.
REQ-021 ready SHALL NOT be asserted in any state other than DONE.
REQ-022 result SHALL read 0 whenever ready=0.

Reset
REQ-023 reset=1 SHALL clear the state to IDLE, the counter to 0, and the operand and result registers to 0; ready SHALL be 0 in the cycle after reset.
REQ-024 Reset during BUSY or DONE SHALL discard the operation with no ready pulse; reset SHALL override valid in the same cycle.

Configuration
REQ-025 Macro XC_AESSUB_FAST_EN, when defined, SHALL instantiate four S-box copies. The block then computes combinationally, with ready = valid in the same cycle and no FSM state used.
REQ-026 Without XC_AESSUB_FAST_EN, exactly one S-box instance SHALL be shared, and the REQ-013..REQ-020 iterative behaviour SHALL apply.
REQ-027 Both builds SHALL produce bit-identical result values for identical rs1, rs2, enc and rot.

Structure
REQ-028 The shared package xc_aes_pkg SHALL hold:
- the FSM state typedef (IDLE, BUSY, DONE);
- the byte-select lookup (rs1/rs2 per byte index);
- the rotate amount constant (8).
REQ-029 Sub-module xc_aes_sbox, a combinational 8-bit in/out with an enc select, SHALL implement both the forward and inverse S-box and be reused by the formal checker.

Verification
REQ-030 Forward, no rot: rs1=0x00530001, rs2=0xff000000, enc=1, rot=0 -> result=0x16ed637c; ready 4 cycles after valid.
REQ-031 Forward with rot: same operands, enc=1, rot=1 -> result=0xed637c16.
REQ-032 Inverse: rs1=0x00ed007c, rs2=0x16006300, enc=0, rot=0 -> result=0xff530001.
REQ-033 Abort: valid dropped in the 2nd BUSY cycle -> no ready pulse; the next request with the REQ-030 operands yields 0x16ed637c.
REQ-034 Reset mid-operation: reset asserted in the 3rd BUSY cycle -> ready stays 0, FSM in IDLE, result=0.
REQ-035 Equivalence: random rs1, rs2, enc and rot with and without XC_AESSUB_FAST_EN -> identical result; ready pulse always exactly one cycle wide.

Source files
------------

// File: rtl/xc_aes_pkg.sv
// Shared types and helpers for the AES byte-substitution unit: FSM states,
// the per-byte operand source map and the result rotation.
package xc_aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit i set means result byte i is taken from rs2, clear means rs1.
    localparam logic [3:0] BYTE_FROM_RS2 = 4'b1010;
    localparam int         ROT_AMT       = 8;

    function automatic logic [7:0] select_byte(input logic [31:0] a,
                                               input logic [31:0] b,
                                               input logic [1:0]  idx);
        logic [31:0] src;
        src = BYTE_FROM_RS2[idx] ? b : a;
        return src[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] rotate_result(input logic [31:0] w,
                                                  input logic        en);
        return en ? {w[31-ROT_AMT:0], w[31:32-ROT_AMT]} : w;
    endfunction

endpackage

// File: rtl/xc_aes_sbox.sv
// Combinational AES S-box, forward (i_enc=1) or inverse (i_enc=0), built from
// the GF(2^8) multiplicative inverse and the affine transform.
module xc_aes_sbox (
    input  logic [7:0] i_byte,
    input  logic       i_enc,
    output logic [7:0] o_byte
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the field inverse, and maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] v);
        return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] v);
        return rotl8(v, 1) ^ rotl8(v, 3) ^ rotl8(v, 6) ^ 8'h05;
    endfunction

    always_comb begin
        o_byte = '0;
        if (i_enc) o_byte = affine(gf_inv(i_byte));
        else       o_byte = gf_inv(inv_affine(i_byte));
    end

endmodule

// File: rtl/xc_aessub_unit.sv
// Packed AES SubBytes unit. Default build shares one S-box over four cycles;
// defining XC_AESSUB_FAST_EN uses four S-boxes and answers combinationally.
module xc_aessub_unit
    import xc_aes_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        valid,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        enc,
    input  logic        rot,
    output logic        ready,
    output logic [31:0] result
);

`ifdef XC_AESSUB_FAST_EN

    logic [31:0] w_sub;

    for (genvar g = 0; g < 4; g++) begin : gSbox
        xc_aes_sbox u_sbox (
            .i_byte (select_byte(rs1, rs2, 2'(g))),
            .i_enc  (enc),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    assign ready  = valid;
    assign result = valid ? rotate_result(w_sub, rot) : '0;

`else

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_cnt;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic        r_enc;
    logic        r_rot;
    logic [31:0] r_result;
    logic [7:0]  w_sbox_in;
    logic [7:0]  w_sbox_out;
    logic        w_sbox_enc;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (valid) w_next_state = BUSY;
            BUSY:    if (!valid) w_next_state = IDLE;
                     else if (r_cnt == 2'd3) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Byte 0 comes straight from the live inputs so the operands only need
    // to be latched once; later bytes come from the latched copies.
    always_comb begin
        w_sbox_in  = select_byte(r_rs1, r_rs2, r_cnt);
        w_sbox_enc = r_enc;
        if (r_state == IDLE) begin
            w_sbox_in  = select_byte(rs1, rs2, 2'd0);
            w_sbox_enc = enc;
        end
    end

    xc_aes_sbox u_sbox (
        .i_byte (w_sbox_in),
        .i_enc  (w_sbox_enc),
        .o_byte (w_sbox_out)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_enc    <= 1'b0;
            r_rot    <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (valid) begin
                        r_rs1    <= rs1;
                        r_rs2    <= rs2;
                        r_enc    <= enc;
                        r_rot    <= rot;
                        r_cnt    <= 2'd1;
                        r_result <= {24'b0, w_sbox_out};
                    end
                end
                BUSY: begin
                    if (valid) begin
                        r_result[{r_cnt, 3'b000} +: 8] <= w_sbox_out;
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready  = (r_state == DONE);
    assign result = ready ? rotate_result(r_result, r_rot) : '0;

`endif

endmodule

// File: tb/tb_xc_aessub_unit.sv
// Self-checking bench for xc_aessub_unit: known vectors, abort/reset/back-to-back
// sequences and randomized operations against a table-based S-box model.
module tb_xc_aessub_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        enc;
    logic        rot;
    logic        ready;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    logic [7:0] fwdTab [256];
    logic [7:0] invTab [256];

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        enc;
        logic        rot;
        logic [31:0] expected;
    } vec_t;

    vec_t vecs [6];

    xc_aessub_unit dut (
        .clock  (clock),
        .reset  (reset),
        .valid  (valid),
        .rs1    (rs1),
        .rs2    (rs2),
        .enc    (enc),
        .rot    (rot),
        .ready  (ready),
        .result (result)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int prod;
        prod = 0;
        for (int i = 0; i < 8; i++)
            if (b[i]) prod = prod ^ (int'(a) << i);
        for (int k = 14; k >= 8; k--)
            if (prod[k]) prod = prod ^ (32'h11b << (k - 8));
        return prod[7:0];
    endfunction

    function automatic logic [7:0] refAffine(input logic [7:0] v);
        logic [7:0] c;
        logic [7:0] o;
        c = 8'h63;
        for (int i = 0; i < 8; i++)
            o[i] = v[i] ^ v[(i + 4) % 8] ^ v[(i + 5) % 8] ^ v[(i + 6) % 8] ^ v[(i + 7) % 8] ^ c[i];
        return o;
    endfunction

    // Field inverse by exhaustive search, forward table by affine map, and the
    // inverse table by inverting the forward permutation.
    task automatic buildTables();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            fwdTab[x] = refAffine(inv);
        end
        for (int x = 0; x < 256; x++) invTab[fwdTab[x]] = 8'(x);
    endtask

    function automatic logic [31:0] refResult(input logic [31:0] a, input logic [31:0] b,
                                              input logic e, input logic r);
        logic [7:0]  src [4];
        logic [31:0] w;
        src[0] = a[7:0];
        src[1] = b[15:8];
        src[2] = a[23:16];
        src[3] = b[31:24];
        for (int i = 0; i < 4; i++) w[8*i +: 8] = e ? fwdTab[src[i]] : invTab[src[i]];
        if (r) w = {w[23:0], w[31:24]};
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // One full operation; inputs are scrambled after the first edge to show
    // the latched operands are used. Checks latency, result and pulse width.
    task automatic applyStimulus(input string name, input logic [31:0] a, input logic [31:0] b,
                                 input logic e, input logic r, input logic [31:0] exp);
        int          lat;
        logic [31:0] res;
        logic        zeroOk;
        @(negedge clock);
        rs1 = a; rs2 = b; enc = e; rot = r; valid = 1'b1;
        lat = 99; res = '0; zeroOk = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clock);
            #1;
            if (c == 1) begin
                rs1 = $urandom; rs2 = $urandom;
                enc = 1'($urandom_range(0, 1)); rot = 1'($urandom_range(0, 1));
            end
            if (ready) begin
                lat = c;
                res = result;
                break;
            end
            if (result !== 32'h0) zeroOk = 1'b0;
        end
        @(negedge clock);
        valid = 1'b0;
        @(posedge clock);
        #1;
        checkOutput({name, " latency"}, 32'(lat), 32'd4);
        checkOutput({name, " result"}, res, exp);
        checkOutput({name, " idle result zero"}, {31'b0, zeroOk}, 32'd1);
        checkOutput({name, " pulse width"}, {31'b0, ready}, 32'd0);
    endtask

    task automatic countReady(input int cycles, output int n);
        n = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clock);
            #1;
            if (ready) n++;
        end
    endtask

    initial begin
        int          n;
        int          gap;
        logic [31:0] ra, rb;
        logic        re, rr;

        buildTables();
        vecs[0] = '{32'h00530001, 32'hff000000, 1'b1, 1'b0, 32'h16ed637c};
        vecs[1] = '{32'h00530001, 32'hff000000, 1'b1, 1'b1, 32'hed637c16};
        vecs[2] = '{32'h00ed007c, 32'h16006300, 1'b0, 1'b0, 32'hff530001};
        vecs[3] = '{32'h00ed007c, 32'h16006300, 1'b0, 1'b1, 32'h530001ff};
        vecs[4] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h63636363};
        vecs[5] = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h52525252};

        reset = 1'b1; valid = 1'b1; rs1 = 32'h00530001; rs2 = 32'hff000000; enc = 1'b1; rot = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset ready", {31'b0, ready}, 32'd0);
        checkOutput("reset result", result, 32'h0);
        @(negedge clock);
        reset = 1'b0; valid = 1'b0;
        countReady(6, n);
        checkOutput("reset overrides valid", 32'(n), 32'd0);

        for (int i = 0; i < 6; i++)
            applyStimulus($sformatf("vec%0d", i), vecs[i].rs1, vecs[i].rs2,
                          vecs[i].enc, vecs[i].rot, vecs[i].expected);

        // Abort: valid low during the second BUSY cycle.
        @(negedge clock);
        rs1 = 32'h00530001; rs2 = 32'hff000000; enc = 1'b1; rot = 1'b0; valid = 1'b1;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        valid = 1'b0;
        countReady(8, n);
        checkOutput("abort no ready", 32'(n), 32'd0);
        applyStimulus("after abort", 32'h00530001, 32'hff000000, 1'b1, 1'b0, 32'h16ed637c);

        // Reset during the third BUSY cycle.
        @(negedge clock);
        rs1 = 32'h00530001; rs2 = 32'hff000000; enc = 1'b1; rot = 1'b1; valid = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("midreset ready", {31'b0, ready}, 32'd0);
        checkOutput("midreset result", result, 32'h0);
        @(negedge clock);
        reset = 1'b0; valid = 1'b0;
        countReady(6, n);
        checkOutput("midreset no ready", 32'(n), 32'd0);
        applyStimulus("after reset", 32'h00530001, 32'hff000000, 1'b1, 1'b1, 32'hed637c16);

        // Back-to-back with valid held high: one result per 5 cycles.
        @(negedge clock);
        rs1 = 32'h00ed007c; rs2 = 32'h16006300; enc = 1'b0; rot = 1'b0; valid = 1'b1;
        n = 0;
        for (int c = 0; c < 12 && !ready; c++) begin
            @(posedge clock);
            #1;
        end
        checkOutput("b2b first", result, 32'hff530001);
        @(negedge clock);
        rs1 = 32'h00530001; rs2 = 32'hff000000; enc = 1'b1; rot = 1'b0;
        gap = 99;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clock);
            #1;
            if (ready) begin
                gap = c;
                break;
            end
        end
        checkOutput("b2b gap", 32'(gap), 32'd5);
        checkOutput("b2b second", result, 32'h16ed637c);
        @(negedge clock);
        valid = 1'b0;
        @(posedge clock);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom; rb = $urandom;
            re = 1'($urandom_range(0, 1)); rr = 1'($urandom_range(0, 1));
            applyStimulus($sformatf("rand%0d", i), ra, rb, re, rr, refResult(ra, rb, re, rr));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
